// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the FIFO write-side arbitration logic.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   rr_pick     : round-robin search of a valid vector starting at an index,
//                 wrapping modulo n (n <= RR_MAX_N). Returns {any, index}.
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int RR_MAX_N = 16;
    localparam int RR_IDX_W = 4;

    // Candidate index is start+k, folded back by one subtraction of n. Since
    // start < n and only k < n is considered, a single fold is an exact
    // modulo, so indices >= n are never produced.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input logic [RR_IDX_W-1:0] start,
        input int                  n
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        int                  cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            cand = int'(start) + k;
            if (cand >= n) cand = cand - n;
            if ((k < n) && !found && valid[cand[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[RR_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin priority encoder.
//   i_valid [N]     : request vector
//   i_start [IDX_W] : highest-priority index (must be < N)
//   o_idx   [IDX_W] : first set bit at or above i_start, wrapping modulo N
//   o_any           : at least one request is set
// ----------------------------------------------------------------------------
module rr_priority_pick
    import fifo_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [RR_MAX_N-1:0] w_valid;
    logic [RR_IDX_W-1:0] w_start;
    logic [RR_IDX_W:0]   w_res;

    // Widen to the helper's fixed size; unused upper requests stay zero.
    always_comb begin
        w_valid          = '0;
        w_valid[N-1:0]   = i_valid;
        w_start          = '0;
        w_start[IDX_W-1:0] = i_start;
        w_res            = rr_pick(w_valid, w_start, N);
        o_idx            = IDX_W'(w_res[RR_IDX_W-1:0]);
        o_any            = w_res[RR_IDX_W];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one sync_fifo write port among N_REQ producers.
// A grant lasts up to MAX_BURST accepted words; each FIFO word is tagged with
// the producer index: fifo_wr_data = {owner, payload}.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid [N]  : producer word offered
//   req_data  [N*DATA_W] : producer i at [i*DATA_W +: DATA_W]
//   req_ready [N]  : producer word accepted (valid & ready)
//   fifo_full      : registered FIFO full flag
//   fifo_wr_en     : FIFO write strobe
//   fifo_wr_data   : {owner tag, payload}
//   grant_id       : current owner, meaningful while busy
//   busy           : burst in progress
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*DATA_W-1:0]           req_data,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic                              fifo_full,
    output logic                              fifo_wr_en,
    output logic [$clog2(N_REQ)+DATA_W-1:0]   fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0]          grant_id,
    output logic                              busy
);

    localparam int TAG_W = $clog2(N_REQ);

    arb_state_e       r_state,    w_state_nxt;
    logic [TAG_W-1:0] r_owner,    w_owner_nxt;
    logic [TAG_W-1:0] r_rr_ptr,   w_rr_nxt;
    logic [7:0]       r_beat_cnt, w_beat_nxt;

    logic [TAG_W-1:0] w_pick;
    logic             w_any;
    logic [TAG_W-1:0] w_owner_inc;
    logic             w_owner_vld;
    logic             w_xfer;
    logic [7:0]       w_beat_inc;
    logic             w_last;
    logic [DATA_W-1:0] w_data [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .N     (N_REQ),
        .IDX_W (TAG_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    // Explicit wrap so non-power-of-two N_REQ never yields an unused index.
    assign w_owner_inc = (r_owner == TAG_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
    assign w_owner_vld = req_valid[r_owner];
    assign busy        = (r_state == BURST);
    // fifo_full gates the write directly, so no write is ever issued into a
    // full FIFO.
    assign w_xfer      = busy & w_owner_vld & ~fifo_full;
    assign w_beat_inc  = r_beat_cnt + 8'd1;
    assign w_last      = (w_beat_inc == 8'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BURST;
                    w_owner_nxt = w_pick;
                    w_beat_nxt  = '0;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    w_beat_nxt = w_beat_inc;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = w_owner_inc;
                    end
                end else if (!fifo_full && !w_owner_vld) begin
                    // Owner went idle; a drop while full does not count.
                    w_state_nxt = IDLE;
                    w_rr_nxt    = w_owner_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (busy && !fifo_full) req_ready[r_owner] = 1'b1;
    end

    assign fifo_wr_en   = w_xfer;
    assign fifo_wr_data = {r_owner, w_data[r_owner]};
    assign grant_id     = r_owner;

endmodule
